// File: rtl/g15_pkg.sv
// Shared G-15 command word layout and decoder state encoding.
// Bit 1 of the serial word is word[0], so each field arrives low bit first.
package g15_pkg;

  localparam int WORD_LEN = 29;
  localparam int CNT_W    = 5;

  localparam logic [CNT_W-1:0] CNT_WORD = 5'd29;
  localparam logic [CNT_W-1:0] CNT_MAX  = 5'd31;

  localparam int DP_POS = 0;
  localparam int D_LSB  = 1;
  localparam int D_W    = 5;
  localparam int S_LSB  = 6;
  localparam int S_W    = 5;
  localparam int C_LSB  = 11;
  localparam int C_W    = 2;
  localparam int N_LSB  = 13;
  localparam int N_W    = 7;
  localparam int BP_POS = 20;
  localparam int T_LSB  = 21;
  localparam int T_W    = 7;
  localparam int ID_POS = 28;

  localparam logic [D_W-1:0] D_SPECIAL = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_HOLD  = 2'b10
  } state_t;

endpackage

// File: rtl/cmd_shift_reg.sv
// Serial-in 29-bit command shift register with saturating bit counter.
// Bits enter at the top and move down, so after 29 bits bit 1 sits at word[0].
module cmd_shift_reg
  import g15_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                shift,
  input  logic                cm,
  output logic [WORD_LEN-1:0] word,
  output logic [CNT_W-1:0]    count
);

  // Load restarts the word with bit 1; shift appends the next bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word  <= '0;
      count <= 5'd0;
    end else if (load) begin
      word  <= {cm, {(WORD_LEN-1){1'b0}}};
      count <= 5'd1;
    end else if (shift) begin
      word <= {cm, word[WORD_LEN-1:1]};
      if (count != CNT_MAX) begin
        count <= count + 5'd1;
      end else begin
        count <= count;
      end
    end else begin
      word  <= word;
      count <= count;
    end
  end

endmodule

// File: rtl/cmd_field_decoder.sv
// Captures the serial command track into a shift register and latches the
// decoded command fields on a correctly framed T29 strobe.
module cmd_field_decoder
  import g15_pkg::*;
(
  input  logic           CLOCK,
  input  logic           rst,
  input  logic           CM,
  input  logic           T0,
  input  logic           T29,
  input  logic           RC,
  input  logic           ERR_CLR,
  output logic           DP,
  output logic [D_W-1:0] D,
  output logic [S_W-1:0] S,
  output logic [C_W-1:0] C,
  output logic [N_W-1:0] N,
  output logic           BP,
  output logic [T_W-1:0] T,
  output logic           ID,
  output logic           DS,
  output logic           CMD_VALID,
  output logic           CMD_NEW,
  output logic           FRAME_ERR
);

  state_t              state;
  logic                load;
  logic                shift;
  logic                latch;
  logic                frame_bad;
  logic [WORD_LEN-1:0] word;
  logic [CNT_W-1:0]    count;

  cmd_shift_reg u_shift (
    .clk   (CLOCK),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .cm    (CM),
    .word  (word),
    .count (count)
  );

  // T29 outranks T0 and an RC drop; a T0 inside a capture restarts it.
  always_comb begin
    load      = 1'b0;
    shift     = 1'b0;
    latch     = 1'b0;
    frame_bad = 1'b0;
    case (state)
      ST_IDLE, ST_HOLD: begin
        if (T0 && RC && !T29) begin
          load = 1'b1;
        end else begin
          load = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (T29) begin
          if (count == CNT_WORD) begin
            latch = 1'b1;
          end else begin
            frame_bad = 1'b1;
          end
        end else if (!RC) begin
          shift = 1'b0;
        end else if (T0) begin
          frame_bad = 1'b1;
          load      = 1'b1;
        end else begin
          shift = 1'b1;
        end
      end
      default: begin
        load = 1'b0;
      end
    endcase
  end

  // FSM, field latches and status flags; everything here is registered.
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      DP        <= 1'b0;
      D         <= '0;
      S         <= '0;
      C         <= '0;
      N         <= '0;
      BP        <= 1'b0;
      T         <= '0;
      ID        <= 1'b0;
      CMD_VALID <= 1'b0;
      CMD_NEW   <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      CMD_NEW <= latch;
      if (latch) begin
        DP        <= word[DP_POS];
        D         <= word[D_LSB +: D_W];
        S         <= word[S_LSB +: S_W];
        C         <= word[C_LSB +: C_W];
        N         <= word[N_LSB +: N_W];
        BP        <= word[BP_POS];
        T         <= word[T_LSB +: T_W];
        ID        <= word[ID_POS];
        CMD_VALID <= 1'b1;
      end
      if (frame_bad) begin
        FRAME_ERR <= 1'b1;
      end else if (ERR_CLR) begin
        FRAME_ERR <= 1'b0;
      end
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (load) begin
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (latch) begin
            state <= ST_HOLD;
          end else if (load || shift) begin
            state <= ST_SHIFT;
          end else begin
            state <= CMD_VALID ? ST_HOLD : ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign DS = CMD_VALID && (D == D_SPECIAL);

endmodule

// File: tb/tb_cmd_field_decoder.sv
// Directed bench for cmd_field_decoder with a bit-queue model checked every cycle.
module tb_cmd_field_decoder;

  logic       clock = 1'b0;
  logic       rst;
  logic       cm, t0, t29, rc, err_clr;
  logic       dp, bp, id, ds, cmd_valid, cmd_new, frame_err;
  logic [4:0] d, s;
  logic [1:0] c;
  logic [6:0] n, t;

  cmd_field_decoder dut (
    .CLOCK(clock), .rst(rst), .CM(cm), .T0(t0), .T29(t29), .RC(rc),
    .ERR_CLR(err_clr), .DP(dp), .D(d), .S(s), .C(c), .N(n), .BP(bp),
    .T(t), .ID(id), .DS(ds), .CMD_VALID(cmd_valid), .CMD_NEW(cmd_new),
    .FRAME_ERR(frame_err)
  );

  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          started = 1'b0;

  // Model state: bits gathered since the last T0, plus the last good word.
  bit          bits[$];
  bit          capturing;
  int unsigned m_word;
  bit          m_valid, m_new, m_err;

  function automatic int unsigned pack(int dpv, int dv, int sv, int cv,
                                       int nv, int bpv, int tv, int idv);
    return dpv + dv * 2 + sv * 64 + cv * 2048 + nv * 8192 + bpv * 1048576
           + tv * 2097152 + idv * 268435456;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    bits.delete();
    capturing = 1'b0;
    m_word    = 0;
    m_valid   = 1'b0;
    m_new     = 1'b0;
    m_err     = 1'b0;
  endtask

  task automatic model_update();
    bit set_err = 1'b0;
    m_new = 1'b0;
    if (capturing) begin
      if (t29) begin
        if (bits.size() == 29) begin
          m_word = 0;
          foreach (bits[i]) if (bits[i]) m_word += (32'd1 << i);
          m_valid = 1'b1;
          m_new   = 1'b1;
        end else begin
          set_err = 1'b1;
        end
        capturing = 1'b0;
        bits.delete();
      end else if (!rc) begin
        capturing = 1'b0;
        bits.delete();
      end else if (t0) begin
        set_err = 1'b1;
        bits.delete();
        bits.push_back(cm);
      end else begin
        bits.push_back(cm);
      end
    end else if (t0 && rc && !t29) begin
      capturing = 1'b1;
      bits.delete();
      bits.push_back(cm);
    end
    if (set_err) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cyc(input logic cmv, input logic t0v, input logic t29v,
                     input logic rcv, input logic clrv);
    cm = cmv; t0 = t0v; t29 = t29v; rc = rcv; err_clr = clrv;
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  task automatic send_bits(input int unsigned w, input int nbits);
    cyc(w[0], 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < nbits; i++) cyc(w[i % 32], 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    int unsigned w;
    forever begin
      @(posedge clock);
      #2;
      if (started) begin
        w = m_valid ? m_word : 0;
        check("DP", int'(dp), int'(w % 2));
        check("D", int'(d), int'((w / 2) % 32));
        check("S", int'(s), int'((w / 64) % 32));
        check("C", int'(c), int'((w / 2048) % 4));
        check("N", int'(n), int'((w / 8192) % 128));
        check("BP", int'(bp), int'((w / 1048576) % 2));
        check("T", int'(t), int'((w / 2097152) % 128));
        check("ID", int'(id), int'((w / 268435456) % 2));
        check("DS", int'(ds), int'(m_valid && ((w / 2) % 32) == 31));
        check("CMD_VALID", int'(cmd_valid), int'(m_valid));
        check("CMD_NEW", int'(cmd_new), int'(m_new));
        check("FRAME_ERR", int'(frame_err), int'(m_err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned cmd_a, cmd_b, cmd_c, cmd_d;
    cmd_a = pack(0, 31, 5, 2, 'h45, 1, 'h12, 1);
    cmd_b = pack(1, 3, 17, 1, 'h2A, 0, 'h55, 0);
    cmd_c = pack(0, 12, 30, 3, 'h11, 1, 'h7F, 0);
    cmd_d = pack(1, 31, 0, 0, 'h7E, 1, 'h01, 1);

    rst = 1'b1; cm = 1'b0; t0 = 1'b0; t29 = 1'b0; rc = 1'b0; err_clr = 1'b0;
    model_reset();
    started = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    rst = 1'b0;
    idle(2);

    // Clean command with D = 31.
    send_bits(cmd_a, 29);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    #3;
    check("lit_word", int'(m_word), int'(29'h1258B17E));
    check("lit_D", int'(d), 31);
    check("lit_S", int'(s), 5);
    check("lit_C", int'(c), 2);
    check("lit_N", int'(n), 'h45);
    check("lit_BP", int'(bp), 1);
    check("lit_T", int'(t), 'h12);
    check("lit_ID", int'(id), 1);
    check("lit_DP", int'(dp), 0);
    check("lit_DS", int'(ds), 1);
    check("lit_NEW", int'(cmd_new), 1);
    check("lit_VALID", int'(cmd_valid), 1);
    idle(3);

    // Short frame: T29 after 27 bits.
    send_bits(cmd_b, 27);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    #3;
    check("lit_short_err", int'(frame_err), 1);
    check("lit_short_D", int'(d), 31);
    idle(2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // T0 again at bit 15, then a clean second command.
    send_bits(cmd_c, 14);
    send_bits(cmd_b, 29);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    #3;
    check("lit_restart_err", int'(frame_err), 1);
    check("lit_restart_S", int'(s), 17);
    idle(2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // RC dropped at bit 10.
    send_bits(cmd_c, 9);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Reset in the middle of a capture, then a full command.
    send_bits(cmd_c, 19);
    rst = 1'b1;
    model_reset();
    @(posedge clock);
    @(negedge clock);
    rst = 1'b0;
    idle(1);
    send_bits(cmd_c, 29);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);

    // ERR_CLR coinciding with a new framing error.
    send_bits(cmd_d, 20);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    #3;
    check("lit_clr_prio", int'(frame_err), 1);
    idle(1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // T0 and T29 together after 29 bits latch as a plain T29.
    send_bits(cmd_d, 29);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(2);
    // T0 with T29 while idle starts nothing.
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(2);

    // Over-long frame: 33 bits saturate the counter.
    send_bits(cmd_a, 33);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_bits(cmd_a, 29);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(3);

    started = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cmd_field_decoder.md
CMD_FIELD_DECODER -- requirements
Module: cmd_field_decoder

Interface
REQ-001 SHALL have ports, clock and reset first: CLOCK in 1 system clock, one bit time per cycle; rst in 1 asynchronous active-high reset.
REQ-002 SHALL have inputs CM (1, serial command-register-track bit, bit 1 first), T0 (1, strobe for bit time of bit 1), T29 (1, strobe for bit time after bit 29), RC (1, Read Command state).
REQ-003 SHALL have outputs: DP (1, bit 1, double-precision prefix); D (5, bits 2-6, destination); S (5, bits 7-11, source); C (2, bits 12-13, characteristic); N (7, bits 14-20, next-command word); BP (1, bit 21, breakpoint); T (7, bits 22-28, timing number); ID (1, bit 29, 1 = deferred).
REQ-004 SHALL have further outputs: DS (1, D == 31 special), CMD_VALID (1, fields hold a complete command), CMD_NEW (1, one-cycle pulse on latch), FRAME_ERR (1, sticky framing error), ERR_CLR (input, 1, clears FRAME_ERR).

Function
REQ-005 SHALL implement states IDLE, SHIFT, HOLD in a 2-bit state register.
REQ-006 IDLE or HOLD: cycle with T0 & RC SHALL enter SHIFT, load CM into shift bit 1 and set bit counter to 1.
REQ-007 SHIFT: each cycle with ~T29 SHALL shift CM into the next position and increment the counter; the counter SHALL saturate at 31.
REQ-008 SHIFT: cycle with T29 and counter == 29 SHALL copy all 29 bits to the field registers, set CMD_VALID, pulse CMD_NEW the next cycle, and enter HOLD.
REQ-009 SHIFT: cycle with T29 and counter != 29 SHALL discard the shift contents, set FRAME_ERR, leave field registers and CMD_VALID unchanged, and enter HOLD if CMD_VALID, else IDLE.
REQ-010 SHIFT: T0 seen again SHALL set FRAME_ERR and restart capture per REQ-006 in the same cycle.
REQ-011 SHIFT: RC deasserted without T29 SHALL abort capture and keep previous fields and CMD_VALID, with no FRAME_ERR; next state HOLD if CMD_VALID, else IDLE.
REQ-012 Field registers SHALL change only on a successful latch (REQ-008); outputs are registered and stable through TR and WTR.
REQ-013 DS SHALL be combinational from the latched D; it SHALL be 0 whenever CMD_VALID = 0.
REQ-014 FRAME_ERR SHALL clear on ERR_CLR; a set condition in the same cycle as ERR_CLR SHALL take priority.
REQ-015 Latency: fields visible the cycle after the T29 strobe; CMD_NEW high exactly that cycle.
REQ-016 T0 and T29 in the same cycle SHALL be treated as T29 only.

Reset
REQ-017 rst SHALL put state = IDLE, counter = 0, shift register = 0, and all outputs = 0 (DP, D, S, C, N, BP, T, ID, DS, CMD_VALID, CMD_NEW, FRAME_ERR).
REQ-018 Reset asserted mid-SHIFT SHALL discard the partial command with no FRAME_ERR.

Structure
REQ-019 Field bit positions, widths, the 29-bit word length constant, and the state enum SHALL live in the shared g15 package.
REQ-020 The 29-bit serial-in shift register with bit counter SHALL be one sub-module, cmd_shift_reg; FSM and field latches stay in the top.

Verification
REQ-021 Serial command D=31, S=5, C=2, N=0x45, BP=1, T=0x12, ID=1, DP=0 with RC high, T0 then 29 bits then T29 -> next cycle fields match, DS=1, CMD_NEW one cycle, CMD_VALID=1.
REQ-022 T29 after 27 bits -> FRAME_ERR=1, fields equal prior command, CMD_NEW never asserted.
REQ-023 T0 re-asserted at bit 15, then 29 clean bits -> FRAME_ERR=1, second command latched correctly.
REQ-024 RC dropped at bit 10 -> no latch, FRAME_ERR=0, previous fields held.
REQ-025 rst pulsed at bit 20, then a full command -> all outputs 0 after reset, new command latched, FRAME_ERR=0.
REQ-026 ERR_CLR with a new framing error in the same cycle -> FRAME_ERR stays 1.
